// File: rtl/lc3_bus_rx.sv
// Bus receiver: classifies the gate enables, samples the bus on ld into a 2-entry FIFO, and reports float/contention/overflow.
// Latency: 1 cycle from ld to out_valid. Backpressure: valid/ready; a legal capture into a full FIFO with no pop is dropped (err_ovf).
module lc3_bus_rx #(
    parameter int WIDTH = 16,
    parameter int NDRV  = 4,
    parameter int SRC_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NDRV-1:0]  gate_en,
    input  logic [WIDTH-1:0] bus,
    input  logic             ld,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SRC_W-1:0] out_src,
    output logic             full,
    output logic             err_float,
    output logic             err_contend,
    output logic             err_ovf,
    input  logic             err_clr,
    output logic [CNT_W-1:0] contend_cnt
);

    localparam int EW = WIDTH + SRC_W;

    logic [1:0][EW-1:0] mem_q, mem_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               full_q, full_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;
    logic               err_float_q, err_float_d;
    logic               err_contend_q, err_contend_d;
    logic               err_ovf_q, err_ovf_d;
    logic [CNT_W-1:0]   contend_cnt_q, contend_cnt_d;

    logic [4:0]         n_en;
    logic [SRC_W-1:0]   src;
    logic               is_float, is_good, is_cont;
    logic               pop, push;

    // Popcount and index of the enabled driver; src is only meaningful when exactly one bit is set.
    always_comb begin
        n_en = '0;
        src  = '0;
        for (int i = 0; i < NDRV; i++) begin
            if (gate_en[i]) begin
                n_en = n_en + 5'd1;
                src  = src | SRC_W'(i);
            end
        end
    end

    assign is_float = (n_en == 5'd0);
    assign is_good  = (n_en == 5'd1);
    assign is_cont  = (n_en >= 5'd2);

    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = ld & is_good & ((cnt_q != 2'd2) | pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
        cnt_d    = cnt_q + 2'(push) - 2'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = {bus, src};
        end
        full_d = (cnt_d == 2'd2);

        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        if (cnt_d != 2'd0) begin
            {out_data_d, out_src_d} = mem_d[rd_ptr_d];
        end

        err_float_d   = (err_float_q   & ~err_clr) | (ld & is_float);
        err_contend_d = (err_contend_q & ~err_clr) | (ld & is_cont);
        err_ovf_d     = (err_ovf_q     & ~err_clr) | (ld & is_good & (cnt_q == 2'd2) & ~pop);

        contend_cnt_d = err_clr ? '0 : contend_cnt_q;
        if (is_cont && (contend_cnt_d != {CNT_W{1'b1}})) begin
            contend_cnt_d = contend_cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q         <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            cnt_q         <= 2'd0;
            full_q        <= 1'b0;
            out_data_q    <= '0;
            out_src_q     <= '0;
            err_float_q   <= 1'b0;
            err_contend_q <= 1'b0;
            err_ovf_q     <= 1'b0;
            contend_cnt_q <= '0;
        end else begin
            mem_q         <= mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            full_q        <= full_d;
            out_data_q    <= out_data_d;
            out_src_q     <= out_src_d;
            err_float_q   <= err_float_d;
            err_contend_q <= err_contend_d;
            err_ovf_q     <= err_ovf_d;
            contend_cnt_q <= contend_cnt_d;
        end
    end

    assign full        = full_q;
    assign out_data    = out_data_q;
    assign out_src     = out_src_q;
    assign err_float   = err_float_q;
    assign err_contend = err_contend_q;
    assign err_ovf     = err_ovf_q;
    assign contend_cnt = contend_cnt_q;

endmodule

// File: tb/tb_lc3_bus_rx.sv
// Bench for lc3_bus_rx: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_lc3_bus_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  gate_en = '0;
    logic [15:0] bus = '0;
    logic        ld = 1'b0;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        out_valid, full, err_float, err_contend, err_ovf;
    logic [15:0] out_data;
    logic [1:0]  out_src;
    logic [7:0]  contend_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [17:0] m_q[$];
    logic [15:0] m_data;
    logic [1:0]  m_src;
    logic        m_float, m_cont, m_ovf;
    int          m_cnt;

    lc3_bus_rx #(.WIDTH(16), .NDRV(4), .SRC_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .gate_en(gate_en), .bus(bus), .ld(ld),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .full(full), .err_float(err_float),
        .err_contend(err_contend), .err_ovf(err_ovf), .err_clr(err_clr),
        .contend_cnt(contend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_data  = '0;
        m_src   = '0;
        m_float = 0;
        m_cont  = 0;
        m_ovf   = 0;
        m_cnt   = 0;
    endtask

    // Called at the clock edge with the inputs that were held across it.
    task automatic model_step();
        int  pc;
        bit  do_pop;
        pc     = $countones(gate_en);
        do_pop = (m_q.size() > 0) && out_ready;
        if (err_clr) begin
            m_float = 0; m_cont = 0; m_ovf = 0; m_cnt = 0;
        end
        if (pc >= 2 && m_cnt < 255) m_cnt++;
        if (do_pop) void'(m_q.pop_front());
        if (ld) begin
            if (pc == 0) m_float = 1;
            else if (pc >= 2) m_cont = 1;
            else if (m_q.size() < 2) m_q.push_back({bus, 2'($clog2(gate_en))});
            else m_ovf = 1;
        end
        if (m_q.size() > 0) {m_data, m_src} = m_q[0];
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("full", 32'(full), 32'(m_q.size() == 2));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_src", 32'(out_src), 32'(m_src));
        chk("err_float", 32'(err_float), 32'(m_float));
        chk("err_contend", 32'(err_contend), 32'(m_cont));
        chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
        chk("contend_cnt", 32'(contend_cnt), 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic [3:0] g, input logic [15:0] b, input logic l,
                         input logic r, input logic c);
        gate_en = g; bus = b; ld = l; out_ready = r; err_clr = c;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Single capture from driver 2
        drive(4'b0100, 16'h3A5C, 1, 1, 0); tick();
        chk("cap_data", 32'(out_data), 32'h3A5C);
        chk("cap_src", 32'(out_src), 32'd2);
        drive(4'b0000, 16'h0000, 0, 1, 0); tick();
        chk("cap_gone", 32'(out_valid), 32'd0);

        // Overflow: three loads with no consumer
        drive(4'b0010, 16'h0001, 1, 0, 0); tick();
        drive(4'b0010, 16'h0002, 1, 0, 0); tick();
        chk("full_after2", 32'(full), 32'd1);
        drive(4'b0010, 16'h0003, 1, 0, 0); tick();
        chk("ovf_after3", 32'(err_ovf), 32'd1);
        drive(4'b0000, 16'h0000, 0, 1, 0); tick();
        chk("pop2_data", 32'(out_data), 32'h0002);
        drive(4'b0000, 16'h0000, 0, 1, 1); tick();
        chk("empty_hold", 32'(out_data), 32'h0002);

        // Full with simultaneous pop and push
        drive(4'b0001, 16'h1111, 1, 0, 0); tick();
        drive(4'b0001, 16'h2222, 1, 0, 0); tick();
        drive(4'b1000, 16'hBEEF, 1, 1, 0); tick();
        chk("pp_no_ovf", 32'(err_ovf), 32'd0);
        chk("pp_full", 32'(full), 32'd1);
        drive(4'b0000, 16'h0000, 0, 1, 0); tick();
        chk("pp_beef", {16'h0, out_data}, 32'hBEEF);
        tick();

        // Float, contention, clear
        drive(4'b0000, 16'h5555, 1, 1, 0); tick();
        chk("float", 32'(err_float), 32'd1);
        drive(4'b0011, 16'h6666, 1, 1, 0); tick();
        chk("contend", 32'(err_contend), 32'd1);
        chk("contend_cnt1", 32'(contend_cnt), 32'd1);
        drive(4'b0000, 16'h0000, 0, 1, 1); tick();
        chk("clr_cnt", 32'(contend_cnt), 32'd0);

        // Counter saturation, then clear in a contending cycle
        drive(4'b1111, 16'h0000, 0, 1, 0);
        repeat (300) tick();
        chk("sat", 32'(contend_cnt), 32'd255);
        chk("sat_noflag", 32'(err_contend), 32'd0);
        drive(4'b1111, 16'h0000, 0, 1, 1); tick();
        chk("clr_cont", 32'(contend_cnt), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int mode;
            logic [3:0] g;
            mode = $urandom_range(0, 9);
            if (mode < 7) g = 4'(1 << $urandom_range(0, 3));
            else if (mode == 7) g = 4'b0000;
            else g = 4'($urandom);
            drive(g, 16'($urandom), ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 19) == 0));
            tick();
        end

        // Asynchronous reset with two entries queued
        drive(4'b0100, 16'hAAAA, 1, 0, 0); tick();
        drive(4'b0011, 16'hBBBB, 1, 0, 0); tick();
        drive(4'b0001, 16'hCCCC, 1, 0, 0); tick();
        drive(4'b0000, 16'h0000, 0, 0, 0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_flags", {29'd0, err_float, err_contend, err_ovf}, 32'd0);
        chk("arst_cnt", 32'(contend_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(4'b1000, 16'h7777, 1, 0, 0); tick();
        chk("post_data", 32'(out_data), 32'h7777);
        drive(4'b0000, 16'h0000, 0, 1, 0); tick();
        chk("post_alone", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
